kbd_ctrl: RTL and testbench
===========================

Name: kbd_ctrl

Overview:
- Sequences the PS/2 scan-code-to-ASCII lookup ROM (256x8, combinational read; unmapped entries read 0x00).
- Consumes raw scan-code bytes from the PS/2 receiver via valid/ready.
- Decodes E0 (extended) and F0 (break) prefixes, tracks the held key and counts distinct presses.
- Drives the ROM address and emits ASCII bytes to the display/console path.

Parameters:
- CNT_W, 8, width of press counter

Ports:
- clk  in  1  system clock
- clrn  in  1  synchronous active-low reset
- byte_valid  in  1  scan byte available from receiver
- byte_data  in  8  scan byte
- byte_ready  out  1  controller accepts byte this cycle
- rom_addr  out  8  ROM address (registered)
- rom_q  in  8  ROM data, valid same cycle as rom_addr
- ascii  out  8  last emitted ASCII code
- ascii_valid  out  1  one-cycle pulse, ascii valid
- key_down  out  1  a key is currently held
- key_scan  out  8  scan code of held/last key
- key_ext  out  1  held/last key was E0-prefixed
- press_cnt  out  CNT_W  count of distinct presses

Behaviour:
- Interface: one clock (clk); synchronous, active-low reset (clrn). clrn low at any edge forces the reset state, overriding everything including an in-flight lookup.
- Reset values:
  - state IDLE, byte_ready 1
  - rom_addr, ascii, key_scan, press_cnt: 0
  - ascii_valid, key_down, key_ext: 0
- States: IDLE, EXT, BRK, EXTBRK, LOOKUP.
- Handshake: a byte transfers on an edge with byte_valid && byte_ready. byte_ready = 1 in all states except LOOKUP. Receiver holds data while not ready.
- IDLE, byte accepted:
  - 0xE0 -> EXT
  - 0xF0 -> BRK
  - otherwise make code m -> LOOKUP, rom_addr<=m
  - If !(key_down && key_scan==m && !key_ext): press_cnt++.
  - key_down<=1, key_scan<=m, key_ext<=0.
- EXT:
  - 0xF0 -> EXTBRK
  - 0xE0 stays in EXT
  - otherwise make m -> IDLE with the same press_cnt rule using ext=1; key_down<=1, key_scan<=m, key_ext<=1. No ROM lookup, no ascii.
- BRK / EXTBRK: byte b -> IDLE. If key_down && key_scan==b && key_ext matches state (BRK=0, EXTBRK=1), key_down<=0. Otherwise ignored. No ascii.
- LOOKUP (exactly 1 cycle): sample rom_q; if nonzero, ascii<=rom_q and ascii_valid<=1 at the exiting edge. -> IDLE.
- Latency: make byte accepted at edge T; ascii_valid high for the cycle after edge T+1; byte_ready low for exactly one cycle.
- ascii_valid is 0 in every cycle not following a LOOKUP.
- Typematic repeat (same make while held): ascii re-emitted, press_cnt unchanged.
- Different make while held: new key replaces old, press_cnt++.
- press_cnt wraps modulo 2^CNT_W (0xFF -> 0x00) without flag.
- rom_q == 0x00 (unmapped): no pulse, ascii holds previous value.
- Stray 0xF0/0xE0 sequences never deadlock: every state returns to IDLE after at most one non-prefix byte.

Optional Feature:
- Macro KBD_SHIFT_UPPER_EN.
- Defined:
  - Track shift_held, set by make 0x12 or 0x59 (non-ext), cleared by matching break.
  - Shift makes/breaks do not update key_down/key_scan/press_cnt and do no lookup.
  - In LOOKUP, if shift_held and rom_q in 0x61..0x7A, emit rom_q-0x20.
- Undefined: 0x12/0x59 handled as ordinary keys (ROM returns 0, so no ascii); letters always lowercase.

Decomposition:
- Package kbd_pkg:
  - state enum
  - constants SC_EXT=0xE0, SC_BRK=0xF0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, ASCII_A_LO=0x61, ASCII_Z_LO=0x7A, CASE_DELTA=0x20
- No sub-module: the ROM is instantiated alongside by the parent. A single FSM plus registers is natural.

Test Plan:
- Feed 0x1C -> one cycle byte_ready=0; ascii_valid pulse with ascii=0x61; key_down=1, key_scan=0x1C, press_cnt=1.
- Feed 0x1C,0x1C,0xF0,0x1C -> two pulses of 0x61; press_cnt=1; key_down=0 after 0xF0 0x1C.
- Feed 0xE0,0x75,0xE0,0xF0,0x75 -> no ascii_valid; key_ext=1, key_scan=0x75, key_down 1 then 0; press_cnt=1.
- Feed 0x0D (unmapped) -> no pulse, ascii unchanged, press_cnt++. Feed 256 distinct alternating presses -> press_cnt wraps to same value.
- Assert clrn=0 in the LOOKUP cycle after 0x16 -> next cycle all outputs reset, no pulse, byte_ready=1.
- With KBD_SHIFT_UPPER_EN: 0x12,0x1C,0xF0,0x12,0x1C -> ascii 0x41 then 0x61. Without the macro: same stimulus gives 0x61 twice.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard controller.
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_LOOKUP
  } kbd_state_e;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_Z_LO = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= ASCII_A_LO && c <= ASCII_Z_LO) return c - CASE_DELTA;
    return c;
  endfunction

endpackage

// File: rtl/kbd_ctrl.sv
// PS/2 scan-code sequencer: prefix decode, held-key tracking, press counting, ROM lookup to ASCII.
// Optional KBD_SHIFT_UPPER_EN: shift keys are tracked and upper-case the emitted letters.
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic [7:0]       rom_addr,
  input  logic [7:0]       rom_q,
  output logic [7:0]       ascii,
  output logic             ascii_valid,
  output logic             key_down,
  output logic [7:0]       key_scan,
  output logic             key_ext,
  output logic [CNT_W-1:0] press_cnt
);

`ifdef KBD_SHIFT_UPPER_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  kbd_state_e       state_q, state_d;
  logic [7:0]       rom_addr_q, rom_addr_d;
  logic [7:0]       ascii_q, ascii_d;
  logic             ascii_valid_q, ascii_valid_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       key_scan_q, key_scan_d;
  logic             key_ext_q, key_ext_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             shift_held_q, shift_held_d;

  logic accept;
  logic is_shift;
  logic brk_ext;

  assign byte_ready = (state_q != ST_LOOKUP);
  assign accept     = byte_valid && byte_ready;
  assign is_shift   = SHIFT_EN && (byte_data == SC_LSHIFT || byte_data == SC_RSHIFT);
  assign brk_ext    = (state_q == ST_EXTBRK);

  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    ascii_d       = ascii_q;
    ascii_valid_d = 1'b0;
    key_down_d    = key_down_q;
    key_scan_d    = key_scan_q;
    key_ext_d     = key_ext_q;
    press_cnt_d   = press_cnt_q;
    shift_held_d  = shift_held_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (byte_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (byte_data == SC_BRK) begin
            state_d = ST_BRK;
          end else if (is_shift) begin
            shift_held_d = 1'b1;
          end else begin
            state_d    = ST_LOOKUP;
            rom_addr_d = byte_data;
            // Typematic repeat of the held key is not a new press.
            if (!(key_down_q && key_scan_q == byte_data && !key_ext_q))
              press_cnt_d = press_cnt_q + CNT_W'(1);
            key_down_d = 1'b1;
            key_scan_d = byte_data;
            key_ext_d  = 1'b0;
          end
        end
      end
      ST_EXT: begin
        if (accept) begin
          if (byte_data == SC_BRK) begin
            state_d = ST_EXTBRK;
          end else if (byte_data != SC_EXT) begin
            state_d = ST_IDLE;
            if (!(key_down_q && key_scan_q == byte_data && key_ext_q))
              press_cnt_d = press_cnt_q + CNT_W'(1);
            key_down_d = 1'b1;
            key_scan_d = byte_data;
            key_ext_d  = 1'b1;
          end
        end
      end
      ST_BRK, ST_EXTBRK: begin
        if (accept) begin
          state_d = ST_IDLE;
          if (is_shift && !brk_ext)
            shift_held_d = 1'b0;
          else if (key_down_q && key_scan_q == byte_data && key_ext_q == brk_ext)
            key_down_d = 1'b0;
        end
      end
      ST_LOOKUP: begin
        state_d = ST_IDLE;
        if (rom_q != 8'h00) begin
          ascii_d       = (SHIFT_EN && shift_held_q) ? to_upper(rom_q) : rom_q;
          ascii_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      rom_addr_q    <= 8'h00;
      ascii_q       <= 8'h00;
      ascii_valid_q <= 1'b0;
      key_down_q    <= 1'b0;
      key_scan_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      press_cnt_q   <= '0;
      shift_held_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      ascii_q       <= ascii_d;
      ascii_valid_q <= ascii_valid_d;
      key_down_q    <= key_down_d;
      key_scan_q    <= key_scan_d;
      key_ext_q     <= key_ext_d;
      press_cnt_q   <= press_cnt_d;
      shift_held_q  <= shift_held_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign ascii       = ascii_q;
  assign ascii_valid = ascii_valid_q;
  assign key_down    = key_down_q;
  assign key_scan    = key_scan_q;
  assign key_ext     = key_ext_q;
  assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed bench for kbd_ctrl: vector table plus reset, counter-wrap and shift sequences.
module tb_kbd_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic [7:0] rom_addr;
  logic [7:0] rom_q;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       key_down;
  logic [7:0] key_scan;
  logic       key_ext;
  logic [7:0] press_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Small lookup ROM model: a few mapped keys, everything else unmapped.
  always_comb begin
    case (rom_addr)
      8'h1C:   rom_q = 8'h61;
      8'h32:   rom_q = 8'h62;
      8'h16:   rom_q = 8'h31;
      default: rom_q = 8'h00;
    endcase
  end

  kbd_ctrl #(.CNT_W(8)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .ascii       (ascii),
    .ascii_valid (ascii_valid),
    .key_down    (key_down),
    .key_scan    (key_scan),
    .key_ext     (key_ext),
    .press_cnt   (press_cnt)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       av;
    logic [7:0] asc;
    logic       kd;
    logic [7:0] ks;
    logic       ke;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Present a byte for one edge, then settle 1 time unit past the edge.
  task automatic step(input logic v, input logic [7:0] d);
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " byte_ready"},  32'(byte_ready),  32'd1);
    check({tag, " ascii_valid"}, 32'(ascii_valid), 32'd0);
    check({tag, " ascii"},       32'(ascii),       32'd0);
    check({tag, " key_down"},    32'(key_down),    32'd0);
    check({tag, " key_scan"},    32'(key_scan),    32'd0);
    check({tag, " key_ext"},     32'(key_ext),     32'd0);
    check({tag, " press_cnt"},   32'(press_cnt),   32'd0);
    check({tag, " rom_addr"},    32'(rom_addr),    32'd0);
  endtask

  initial begin
    int pulses;
    logic [7:0] code;
    logic [7:0] exp_first;

    //          v  d      rdy av  asc    kd ks     ke cnt
    vecs[0]  = '{1, 8'h1C, 0, 0, 8'h00, 1, 8'h1C, 0, 8'd1};
    vecs[1]  = '{0, 8'h00, 1, 1, 8'h61, 1, 8'h1C, 0, 8'd1};
    vecs[2]  = '{1, 8'h1C, 0, 0, 8'h61, 1, 8'h1C, 0, 8'd1};
    vecs[3]  = '{0, 8'h00, 1, 1, 8'h61, 1, 8'h1C, 0, 8'd1};
    vecs[4]  = '{1, 8'hF0, 1, 0, 8'h61, 1, 8'h1C, 0, 8'd1};
    vecs[5]  = '{1, 8'h1C, 1, 0, 8'h61, 0, 8'h1C, 0, 8'd1};
    vecs[6]  = '{1, 8'hE0, 1, 0, 8'h61, 0, 8'h1C, 0, 8'd1};
    vecs[7]  = '{1, 8'h75, 1, 0, 8'h61, 1, 8'h75, 1, 8'd2};
    vecs[8]  = '{1, 8'hE0, 1, 0, 8'h61, 1, 8'h75, 1, 8'd2};
    vecs[9]  = '{1, 8'hF0, 1, 0, 8'h61, 1, 8'h75, 1, 8'd2};
    vecs[10] = '{1, 8'h75, 1, 0, 8'h61, 0, 8'h75, 1, 8'd2};
    vecs[11] = '{1, 8'h0D, 0, 0, 8'h61, 1, 8'h0D, 0, 8'd3};
    vecs[12] = '{0, 8'h00, 1, 0, 8'h61, 1, 8'h0D, 0, 8'd3};
    vecs[13] = '{1, 8'hF0, 1, 0, 8'h61, 1, 8'h0D, 0, 8'd3};
    vecs[14] = '{1, 8'hF0, 1, 0, 8'h61, 1, 8'h0D, 0, 8'd3};
    vecs[15] = '{1, 8'h32, 0, 0, 8'h61, 1, 8'h32, 0, 8'd4};
    vecs[16] = '{0, 8'h00, 1, 1, 8'h62, 1, 8'h32, 0, 8'd4};
    vecs[17] = '{1, 8'hE0, 1, 0, 8'h62, 1, 8'h32, 0, 8'd4};
    vecs[18] = '{1, 8'hE0, 1, 0, 8'h62, 1, 8'h32, 0, 8'd4};
    vecs[19] = '{1, 8'h32, 1, 0, 8'h62, 1, 8'h32, 1, 8'd5};
    vecs[20] = '{1, 8'h1C, 0, 0, 8'h62, 1, 8'h1C, 0, 8'd6};
    vecs[21] = '{1, 8'h1C, 1, 1, 8'h61, 1, 8'h1C, 0, 8'd6};
    vecs[22] = '{0, 8'h00, 1, 0, 8'h61, 1, 8'h1C, 0, 8'd6};

    clrn       = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    clrn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d byte_ready", i),  32'(byte_ready),  32'(vecs[i].rdy));
      check($sformatf("vec%0d ascii_valid", i), 32'(ascii_valid), 32'(vecs[i].av));
      check($sformatf("vec%0d ascii", i),       32'(ascii),       32'(vecs[i].asc));
      check($sformatf("vec%0d key_down", i),    32'(key_down),    32'(vecs[i].kd));
      check($sformatf("vec%0d key_scan", i),    32'(key_scan),    32'(vecs[i].ks));
      check($sformatf("vec%0d key_ext", i),     32'(key_ext),     32'(vecs[i].ke));
      check($sformatf("vec%0d press_cnt", i),   32'(press_cnt),   32'(vecs[i].cnt));
    end

    // 256 alternating distinct presses bring the 8-bit counter back to 6.
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      code = (i % 2 == 0) ? 8'h32 : 8'h1C;
      step(1'b1, code);
      step(1'b0, 8'h00);
      if (ascii_valid) pulses++;
      if (i == 0) check("wrap first press_cnt", 32'(press_cnt), 32'd7);
    end
    check("wrap press_cnt", 32'(press_cnt), 32'd6);
    check("wrap pulses", 32'(pulses), 32'd256);
    check("wrap last ascii", 32'(ascii), 32'h61);

    // Reset asserted during the lookup cycle wins over the pending emit.
    step(1'b1, 8'h16);
    check("pre-reset byte_ready", 32'(byte_ready), 32'd0);
    check("pre-reset rom_addr", 32'(rom_addr), 32'h16);
    clrn = 1'b0;
    step(1'b0, 8'h00);
    check_reset("lookup reset");
    clrn = 1'b1;
    step(1'b0, 8'h00);
    check("post-reset ascii_valid", 32'(ascii_valid), 32'd0);

`ifdef KBD_SHIFT_UPPER_EN
    exp_first = 8'h41;
`else
    exp_first = 8'h61;
`endif
    step(1'b1, 8'h12);
    step(1'b0, 8'h00);
    step(1'b1, 8'h1C);
    step(1'b0, 8'h00);
    check("shift first ascii_valid", 32'(ascii_valid), 32'd1);
    check("shift first ascii", 32'(ascii), 32'(exp_first));
    step(1'b1, 8'hF0);
    step(1'b1, 8'h12);
    step(1'b1, 8'h1C);
    step(1'b0, 8'h00);
    check("shift second ascii_valid", 32'(ascii_valid), 32'd1);
    check("shift second ascii", 32'(ascii), 32'h61);
`ifdef KBD_SHIFT_UPPER_EN
    check("shift press_cnt", 32'(press_cnt), 32'd1);
`else
    check("shift press_cnt", 32'(press_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
